// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: tracks in-flight register writes and stalls readers until the write lands.
// Optional macro HAZARD_FORWARD_EN: only a producer from the previous cycle causes a hazard (execute forwarding).
module hazard_scoreboard #(
    parameter int LATENCY         = 3,
    parameter int REG_COUNT       = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic                       id_read_enable1,
    input  logic [ADDR_WIDTH-1:0]      id_read_addr1,
    input  logic                       id_read_enable2,
    input  logic [ADDR_WIDTH-1:0]      id_read_addr2,
    input  logic                       id_write_enable,
    input  logic [ADDR_WIDTH-1:0]      id_write_addr,
    input  logic                       flush,
    output logic                       stall,
    output logic                       issue,
    output logic [ADDR_WIDTH-1:0]      hazard_addr,
    output logic [1:0]                 state,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    // Handshake: decode presents id_valid; the instruction leaves decode in the
    // same cycle when issue=1, and is held in place while stall=1. flush drops it.

    localparam logic [2:0] LAT3 = 3'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    logic [2:0] pend      [REG_COUNT];
    logic [2:0] pend_next [REG_COUNT];
    logic       hazard1;
    logic       hazard2;
    logic       load_en;
    logic       any_pend_next;

    function automatic logic is_hot(input logic [2:0] cnt);
`ifdef HAZARD_FORWARD_EN
        return cnt == LAT3;
`else
        return cnt != 3'd0;
`endif
    endfunction

    always_comb begin
        hazard1 = id_read_enable1 && (id_read_addr1 != '0) && is_hot(pend[id_read_addr1]);
        hazard2 = id_read_enable2 && (id_read_addr2 != '0) && is_hot(pend[id_read_addr2]);
    end

    // Outputs are forced low during reset so downstream enables see a clean bubble.
    always_comb begin
        stall       = !reset && id_valid && (hazard1 || hazard2) && !flush;
        issue       = !reset && id_valid && !stall && !flush;
        hazard_addr = '0;
        if (stall) begin
            if (hazard1) hazard_addr = id_read_addr1;
            else         hazard_addr = id_read_addr2;
        end
    end

    assign load_en = issue && id_write_enable && (id_write_addr != '0);

    // Load beats decrement, so a back-to-back rewrite restarts the full latency.
    always_comb begin
        any_pend_next = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
            pend_next[r] = pend[r];
            if (pend[r] != 3'd0) pend_next[r] = pend[r] - 3'd1;
            if (load_en && (id_write_addr == ADDR_WIDTH'(r))) pend_next[r] = LAT3;
            if (r == 0) pend_next[r] = 3'd0;
            if (pend_next[r] != 3'd0) any_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_COUNT; r++) pend[r] <= 3'd0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) pend[r] <= pend_next[r];
        end
    end

    always_comb begin
        nxt_state = ST_IDLE;
        if (stall)              nxt_state = ST_STALL;
        else if (any_pend_next) nxt_state = ST_BUSY;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur_state <= ST_IDLE;
        else       cur_state <= nxt_state;
    end

    assign state = cur_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: driver pushes expected outputs per cycle, monitor pops and compares.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int CW = 16;
    localparam int EW = 1 + 1 + AW + 2 + CW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic          id_read_enable1 = 1'b0;
    logic [AW-1:0] id_read_addr1 = '0;
    logic          id_read_enable2 = 1'b0;
    logic [AW-1:0] id_read_addr2 = '0;
    logic          id_write_enable = 1'b0;
    logic [AW-1:0] id_write_addr = '0;
    logic          flush = 1'b0;
    logic          stall;
    logic          issue;
    logic [AW-1:0] hazard_addr;
    logic [1:0]    state;
    logic [CW-1:0] stall_count;

    logic [EW-1:0] exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;

    hazard_scoreboard #(
        .LATENCY(3), .REG_COUNT(32), .ADDR_WIDTH(AW), .STALL_CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_read_enable1(id_read_enable1), .id_read_addr1(id_read_addr1),
        .id_read_enable2(id_read_enable2), .id_read_addr2(id_read_addr2),
        .id_write_enable(id_write_enable), .id_write_addr(id_write_addr),
        .flush(flush), .stall(stall), .issue(issue), .hazard_addr(hazard_addr),
        .state(state), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    // Inputs change on negedge; sampled 4 time units later, just before the rising edge.
    task automatic vec(input logic v, input logic r1e, input logic [AW-1:0] a1,
                       input logic r2e, input logic [AW-1:0] a2,
                       input logic we, input logic [AW-1:0] wa,
                       input logic fl, input logic rs,
                       input logic es, input logic ei, input logic [AW-1:0] eh,
                       input logic [1:0] est, input logic [CW-1:0] ec);
        @(negedge clock);
        reset           = rs;
        id_valid        = v;
        id_read_enable1 = r1e;
        id_read_addr1   = a1;
        id_read_enable2 = r2e;
        id_read_addr2   = a2;
        id_write_enable = we;
        id_write_addr   = wa;
        flush           = fl;
        exp_q.push_back({es, ei, eh, est, ec});
    endtask

    always @(negedge clock) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        #4;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {stall, issue, hazard_addr, state, stall_count};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d: got stall=%b issue=%b haddr=%0d state=%0d cnt=%0d, want stall=%b issue=%b haddr=%0d state=%0d cnt=%0d",
                         vectors, a[EW-1], a[EW-2], a[EW-3 -: AW], a[CW+1 -: 2], a[CW-1:0],
                         e[EW-1], e[EW-2], e[EW-3 -: AW], e[CW+1 -: 2], e[CW-1:0]);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached with %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, then idle
        vec(0,0,0,0,0,0,0,0,1, 0,0,0,0,0);
        for (int i = 0; i < 5; i++) vec(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
        // write r5, then read r5: three stall cycles
        vec(1,0,0,0,0,1,5,0,0, 0,1,0,0,0);
        vec(1,1,5,0,0,0,0,0,0, 1,0,5,1,0);
        vec(1,1,5,0,0,0,0,0,0, 1,0,5,2,1);
        vec(1,1,5,0,0,0,0,0,0, 1,0,5,2,2);
        vec(1,1,5,0,0,0,0,0,0, 0,1,0,2,3);
        // r0 never pends
        vec(1,0,0,0,0,1,0,0,0, 0,1,0,0,3);
        vec(1,1,0,1,0,0,0,0,0, 0,1,0,0,3);
        vec(0,0,0,0,0,0,0,0,0, 0,0,0,0,3);
        // r2 then r7, read r7 on port 1 and r2 on port 2
        vec(1,0,0,0,0,1,2,0,0, 0,1,0,0,3);
        vec(1,0,0,0,0,1,7,0,0, 0,1,0,1,3);
        vec(1,1,7,1,2,0,0,0,0, 1,0,7,1,3);
        vec(1,1,7,1,2,0,0,0,0, 1,0,7,2,4);
        vec(1,1,7,1,2,0,0,0,0, 1,0,7,2,5);
        vec(1,1,7,1,2,0,0,0,0, 0,1,0,2,6);
        // flush in the second stall cycle on r4 (with a write to r4 that must not load)
        vec(1,0,0,0,0,1,4,0,0, 0,1,0,0,6);
        vec(1,1,4,0,0,0,0,0,0, 1,0,4,1,6);
        vec(1,1,4,0,0,1,4,1,0, 0,0,0,2,7);
        vec(1,1,4,0,0,0,0,0,0, 1,0,4,1,7);
        vec(1,1,4,0,0,0,0,0,0, 0,1,0,2,8);
        // r3 <- r3 does not stall on itself; then port 2 alone reports r3
        vec(1,1,3,0,0,1,3,0,0, 0,1,0,0,8);
        vec(0,0,0,0,0,0,0,0,0, 0,0,0,1,8);
        vec(1,1,1,1,3,0,0,0,0, 1,0,3,1,8);
        vec(0,1,1,1,3,0,0,0,0, 0,0,0,2,9);
        vec(0,0,0,0,0,0,0,0,0, 0,0,0,0,9);
        // write r9, reset asynchronously mid-stall, r9 clear afterwards
        vec(1,0,0,0,0,1,9,0,0, 0,1,0,0,9);
        vec(1,1,9,0,0,0,0,0,0, 1,0,9,1,9);
        vec(1,1,9,0,0,0,0,0,1, 0,0,0,0,0);
        vec(1,1,9,0,0,0,0,0,0, 0,1,0,0,0);
        vec(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
        @(posedge clock);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
